// File: rtl/fft_magnitude_stream.sv
// Streaming magnitude-squared stage (re^2 + im^2 per lane) with frame position tracking.
// Optional per-frame peak tracker compiled in with `define MAG_PEAK_TRACK_EN.
module fft_magnitude_stream #(
    parameter  int SAMPLE_SIZE = 16,
    parameter  int BUFFER_SIZE = 512,
    parameter  int LANES       = 4,
    localparam int MAG_WIDTH   = 2 * SAMPLE_SIZE,
    localparam int BIN_WIDTH   = $clog2(BUFFER_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*SAMPLE_SIZE-1:0] in_real,
    input  logic [LANES*SAMPLE_SIZE-1:0] in_imag,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*MAG_WIDTH-1:0]   out_mags,
    output logic                         out_last,
    output logic [BIN_WIDTH-1:0]         out_bin_base,
    output logic                         frame_error
`ifdef MAG_PEAK_TRACK_EN
    ,
    output logic                         peak_valid,
    output logic [BIN_WIDTH-1:0]         peak_bin,
    output logic [MAG_WIDTH-1:0]         peak_mag
`endif
);

    localparam int BEATS      = BUFFER_SIZE / LANES;
    localparam int LANE_SHIFT = $clog2(LANES);

    // Handshake: a beat moves on valid && ready; the whole pipe advances together
    // whenever the output register is empty or being drained, and in_ready mirrors that.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic                          s1_valid, s1_last;
    logic signed [SAMPLE_SIZE-1:0] s1_re [LANES];
    logic signed [SAMPLE_SIZE-1:0] s1_im [LANES];
    logic                          s2_valid, s2_last;
    logic signed [MAG_WIDTH-1:0]   s2_rr [LANES];
    logic signed [MAG_WIDTH-1:0]   s2_ii [LANES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_mags  <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_re[k] <= '0;
                s1_im[k] <= '0;
                s2_rr[k] <= '0;
                s2_ii[k] <= '0;
            end
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_last   <= in_valid && in_last;
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            out_valid <= s2_valid;
            out_last  <= s2_last;
            for (int k = 0; k < LANES; k++) begin
                s1_re[k] <= in_real[k*SAMPLE_SIZE +: SAMPLE_SIZE];
                s1_im[k] <= in_imag[k*SAMPLE_SIZE +: SAMPLE_SIZE];
                // Squares are non-negative and at most 2^(2*SAMPLE_SIZE-2), so the
                // unsigned sum below always fits MAG_WIDTH exactly.
                s2_rr[k] <= MAG_WIDTH'(s1_re[k]) * MAG_WIDTH'(s1_re[k]);
                s2_ii[k] <= MAG_WIDTH'(s1_im[k]) * MAG_WIDTH'(s1_im[k]);
                out_mags[k*MAG_WIDTH +: MAG_WIDTH] <= $unsigned(s2_rr[k] + s2_ii[k]);
            end
        end
    end

    logic [BIN_WIDTH-1:0] count;
    logic                 out_xfer;
    logic                 final_beat;
    assign out_xfer     = out_valid && out_ready;
    assign final_beat   = (count == BIN_WIDTH'(BEATS - 1));
    assign out_bin_base = count << LANE_SHIFT;

    // Both an early last and a missing last restart the frame at bin 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (out_xfer) begin
                frame_error <= (out_last != final_beat);
                count       <= (out_last || final_beat) ? '0 : count + 1'b1;
            end
        end
    end

`ifdef MAG_PEAK_TRACK_EN
    logic [MAG_WIDTH-1:0] beat_mag, run_mag, cand_mag;
    logic [BIN_WIDTH-1:0] beat_bin, run_bin, cand_bin;
    logic                 take_beat;

    // Strict compares keep the lowest bin on ties, within a beat and across beats.
    always_comb begin
        beat_mag = out_mags[0 +: MAG_WIDTH];
        beat_bin = out_bin_base;
        for (int k = 1; k < LANES; k++) begin
            if (out_mags[k*MAG_WIDTH +: MAG_WIDTH] > beat_mag) begin
                beat_mag = out_mags[k*MAG_WIDTH +: MAG_WIDTH];
                beat_bin = out_bin_base + BIN_WIDTH'(k);
            end
        end
        take_beat = (count == '0) || (beat_mag > run_mag);
        cand_mag  = take_beat ? beat_mag : run_mag;
        cand_bin  = take_beat ? beat_bin : run_bin;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_mag    <= '0;
            run_bin    <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
        end else begin
            peak_valid <= 1'b0;
            if (out_xfer) begin
                run_mag <= cand_mag;
                run_bin <= cand_bin;
                if (out_last || final_beat) begin
                    peak_valid <= 1'b1;
                    peak_bin   <= cand_bin;
                    peak_mag   <= cand_mag;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_magnitude_stream.sv
// Directed + randomized bench for fft_magnitude_stream against a frame-level reference model.
// Define MAG_PEAK_TRACK_EN for both bench and RTL to exercise the peak tracker.
module tb_fft_magnitude_stream;

    localparam int SS    = 16;
    localparam int BS    = 512;
    localparam int LN    = 4;
    localparam int MW    = 2 * SS;
    localparam int BW    = $clog2(BS);
    localparam int BEATS = BS / LN;
    localparam int DW    = LN * MW;
    localparam int W     = DW + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_last;
    logic [LN*SS-1:0]  in_real, in_imag;
    logic              out_valid, out_ready, out_last, frame_error;
    logic [DW-1:0]     out_mags;
    logic [BW-1:0]     out_bin_base;
`ifdef MAG_PEAK_TRACK_EN
    logic              peak_valid;
    logic [BW-1:0]     peak_bin;
    logic [MW-1:0]     peak_mag;
`endif

    always #5 clk = ~clk;

    fft_magnitude_stream #(.SAMPLE_SIZE(SS), .BUFFER_SIZE(BS), .LANES(LN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mags(out_mags), .out_last(out_last),
        .out_bin_base(out_bin_base), .frame_error(frame_error)
`ifdef MAG_PEAK_TRACK_EN
        , .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_mag(peak_mag)
`endif
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  exp_q[$];
    int            cyc = 0;
    int            mdl_pos;
    bit            exp_ferr;
    bit            rand_ready;
    bit            was_stalled;
    logic [DW-1:0] snap_mags;
    logic          snap_last;
    logic [BW-1:0] snap_bin;
    int            first_ov_cyc;
    logic [DW-1:0] last_mags;
    int            ferr_seen;
    logic          drv_valid, drv_last;
    logic [LN*SS-1:0] drv_re, drv_im;
`ifdef MAG_PEAK_TRACK_EN
    longint        best;
    int            best_bin;
    bit            exp_pv;
    logic [BW-1:0] exp_pbin;
    logic [MW-1:0] exp_pmag;
`endif

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] calc_mags(input logic [LN*SS-1:0] re, input logic [LN*SS-1:0] im);
        logic [DW-1:0]         r;
        logic signed [SS-1:0]  a, b;
        longint                m;
        for (int k = 0; k < LN; k++) begin
            a = re[k*SS +: SS];
            b = im[k*SS +: SS];
            m = longint'(a) * longint'(a) + longint'(b) * longint'(b);
            r[k*MW +: MW] = m[MW-1:0];
        end
        return r;
    endfunction

    function automatic logic [LN*SS-1:0] rand_vec(input int lim);
        logic [LN*SS-1:0] v;
        for (int k = 0; k < LN; k++) begin
            if (lim == 0) v[k*SS +: SS] = SS'($urandom);
            else          v[k*SS +: SS] = SS'(int'($urandom_range(0, 2 * lim)) - lim);
        end
        return v;
    endfunction

    // One clock: check registered outputs, drive inputs, then score transfers.
    task automatic cycle(output bit accepted);
        logic [W-1:0] e;
        bit           fin;
        @(negedge clk);
        cyc++;
        check("frame_error", W'(frame_error), W'(exp_ferr));
        if (frame_error) ferr_seen++;
        exp_ferr = 1'b0;
`ifdef MAG_PEAK_TRACK_EN
        check("peak_valid", W'(peak_valid), W'(exp_pv));
        check("peak_bin", W'(peak_bin), W'(exp_pbin));
        check("peak_mag", W'(peak_mag), W'(exp_pmag));
        exp_pv = 1'b0;
`endif
        if (was_stalled) begin
            check("stall_valid", W'(out_valid), W'(1));
            check("stall_mags", W'(out_mags), W'(snap_mags));
            check("stall_last", W'(out_last), W'(snap_last));
            check("stall_bin", W'(out_bin_base), W'(snap_bin));
        end
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        in_valid  = drv_valid;
        in_real   = drv_re;
        in_imag   = drv_im;
        in_last   = drv_last;
        #1;
        check("in_ready", W'(in_ready), W'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", W'(1), W'(0));
            end else begin
                e = exp_q.pop_front();
                check("out_mags", W'(out_mags), W'(e[DW-1:0]));
                check("out_last", W'(out_last), W'(e[DW]));
                check("out_bin_base", W'(out_bin_base), W'(mdl_pos * LN));
                fin = (mdl_pos == BEATS - 1);
`ifdef MAG_PEAK_TRACK_EN
                for (int k = 0; k < LN; k++) begin
                    if (longint'(e[k*MW +: MW]) > best) begin
                        best     = longint'(e[k*MW +: MW]);
                        best_bin = mdl_pos * LN + k;
                    end
                end
                if (e[DW] || fin) begin
                    exp_pv   = 1'b1;
                    exp_pbin = BW'(best_bin);
                    exp_pmag = MW'(best);
                    best     = -1;
                end
`endif
                exp_ferr  = (e[DW] != fin);
                mdl_pos   = (e[DW] || fin) ? 0 : mdl_pos + 1;
                last_mags = out_mags;
            end
        end
        was_stalled = out_valid && !out_ready;
        snap_mags   = out_mags;
        snap_last   = out_last;
        snap_bin    = out_bin_base;
        accepted    = in_valid && in_ready;
        if (accepted) exp_q.push_back({in_last, calc_mags(in_real, in_imag)});
    endtask

    task automatic send_beat(input logic [LN*SS-1:0] re, input logic [LN*SS-1:0] im, input bit last);
        bit acc = 1'b0;
        drv_valid = 1'b1;
        drv_re    = re;
        drv_im    = im;
        drv_last  = last;
        for (int t = 0; t < 200; t++) begin
            cycle(acc);
            if (acc) break;
        end
        if (!acc) check("send_timeout", W'(1), W'(0));
        drv_valid = 1'b0;
        drv_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int t = 0; t < n; t++) cycle(acc);
    endtask

    task automatic drain();
        bit acc;
        for (int t = 0; t < 400; t++) begin
            if (exp_q.size() == 0) break;
            cycle(acc);
        end
        if (exp_q.size() != 0) check("drain_timeout", W'(exp_q.size()), W'(0));
        idle(4);
    endtask

    task automatic send_frame(input int nbeats, input int last_at, input bit gaps);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            send_beat(rand_vec(0), rand_vec(0), b == last_at);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        mdl_pos     = 0;
        exp_ferr    = 1'b0;
        was_stalled = 1'b0;
`ifdef MAG_PEAK_TRACK_EN
        best     = -1;
        best_bin = 0;
        exp_pv   = 1'b0;
        exp_pbin = '0;
        exp_pmag = '0;
        check("rst_peak_valid", W'(peak_valid), W'(0));
        check("rst_peak_bin", W'(peak_bin), W'(0));
        check("rst_peak_mag", W'(peak_mag), W'(0));
`endif
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_mags", W'(out_mags), W'(0));
        check("rst_out_last", W'(out_last), W'(0));
        check("rst_bin_base", W'(out_bin_base), W'(0));
        check("rst_frame_error", W'(frame_error), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [LN*SS-1:0] re_v, im_v;
        logic [DW-1:0]    want;
        int               c0, acc_cyc;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_real = '0; in_imag = '0;
        drv_valid = 1'b0; drv_last = 1'b0; drv_re = '0; drv_im = '0;
        rand_ready = 1'b0; was_stalled = 1'b0; exp_ferr = 1'b0; ferr_seen = 0;
        first_ov_cyc = -1; last_mags = '0; mdl_pos = 0;
        do_reset(2);

        // Single beat: latency and exact corner-case magnitudes.
        re_v = {16'h8000, 16'h0000, 16'hFFFC, 16'h0003};
        im_v = {16'h8000, 16'h0000, 16'h0003, 16'h0004};
        first_ov_cyc = -1;
        send_beat(re_v, im_v, 1'b0);
        acc_cyc = cyc;
        drain();
        check("latency", W'(first_ov_cyc - acc_cyc), W'(3));
        want = {32'h8000_0000, 32'd0, 32'd25, 32'd25};
        check("single_mags", W'(last_mags), W'(want));

        // Full frame back-to-back at full rate.
        do_reset(1);
        ferr_seen = 0;
        c0 = cyc;
        send_frame(BEATS, BEATS - 1, 1'b0);
        check("throughput", W'(cyc - c0), W'(BEATS));
        drain();
        check("stream_ferr_count", W'(ferr_seen), W'(0));

        // Three frames with random backpressure and input gaps.
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(BEATS, BEATS - 1, 1'b1);
        drain();
        rand_ready = 1'b0;

        // Early last on beat 10, a good frame, a frame missing its last, a good frame.
        ferr_seen = 0;
        send_frame(11, 10, 1'b0);
        send_frame(BEATS, BEATS - 1, 1'b0);
        send_frame(BEATS, -1, 1'b0);
        send_frame(BEATS, BEATS - 1, 1'b0);
        drain();
        check("framing_ferr_count", W'(ferr_seen), W'(2));

        // Reset with beats in flight: nothing stale may emerge.
        for (int b = 0; b < 3; b++) send_beat(rand_vec(0), rand_vec(0), 1'b0);
        do_reset(1);
        idle(6);
        send_beat(rand_vec(0), rand_vec(0), 1'b0);
        drain();
        do_reset(1);

`ifdef MAG_PEAK_TRACK_EN
        // Peak 900 at bins 37 and 200; everything else at most 98.
        rand_ready = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            re_v = rand_vec(7);
            im_v = rand_vec(7);
            if (b == 9)  begin re_v[SS +: SS] = 16'd30; im_v[SS +: SS] = 16'd0; end
            if (b == 50) begin re_v[0 +: SS]  = 16'd0;  im_v[0 +: SS]  = 16'hFFE2; end
            send_beat(re_v, im_v, b == BEATS - 1);
        end
        drain();
        check("peak_bin_37", W'(peak_bin), W'(37));
        check("peak_mag_900", W'(peak_mag), W'(900));
        for (int b = 0; b < BEATS; b++) send_beat('0, '0, b == BEATS - 1);
        drain();
        check("zero_peak_bin", W'(peak_bin), W'(0));
        check("zero_peak_mag", W'(peak_mag), W'(0));
        rand_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
